// File: rtl/ddr3_app_arb.sv
// ddr3_app_arb: two-port round-robin arbiter and sequencer for the MIG
// app_* interface, with an in-order tag FIFO steering read returns.
//
// Ports (all in the sys_clk / MIG ui_clk domain):
//   sys_clk, sys_rst (sync, active-high), init_calib_complete
//   pN_cmd_valid/ready/rnw, pN_addr, pN_wdata, pN_wmask  (N = 0,1)
//   pN_rvalid, rdata            read data back to the requesters
//   app_en/cmd/addr, app_rdy    MIG command channel
//   app_wdf_wren/end/data/mask, app_wdf_rdy  MIG write-data channel
//   app_rd_data, app_rd_data_valid           MIG read return
//   rd_orphan                   sticky: read beat arrived with no tag
//
// Build option: DDR3_ARB_PRIO_EN selects fixed priority (port 0 wins
// ties) instead of round-robin.

module ddr3_app_arb #(
    parameter int C_ADDR_WIDTH = 28,
    parameter int C_DATA_WIDTH = 256,
    parameter int C_TAG_DEPTH  = 16
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      init_calib_complete,

    input  logic                      p0_cmd_valid,
    output logic                      p0_cmd_ready,
    input  logic                      p0_cmd_rnw,
    input  logic [C_ADDR_WIDTH-1:0]   p0_addr,
    input  logic [C_DATA_WIDTH-1:0]   p0_wdata,
    input  logic [C_DATA_WIDTH/8-1:0] p0_wmask,
    output logic                      p0_rvalid,

    input  logic                      p1_cmd_valid,
    output logic                      p1_cmd_ready,
    input  logic                      p1_cmd_rnw,
    input  logic [C_ADDR_WIDTH-1:0]   p1_addr,
    input  logic [C_DATA_WIDTH-1:0]   p1_wdata,
    input  logic [C_DATA_WIDTH/8-1:0] p1_wmask,
    output logic                      p1_rvalid,

    output logic [C_DATA_WIDTH-1:0]   rdata,

    output logic                      app_en,
    output logic [2:0]                app_cmd,
    output logic [C_ADDR_WIDTH-1:0]   app_addr,
    input  logic                      app_rdy,

    output logic                      app_wdf_wren,
    output logic                      app_wdf_end,
    output logic [C_DATA_WIDTH-1:0]   app_wdf_data,
    output logic [C_DATA_WIDTH/8-1:0] app_wdf_mask,
    input  logic                      app_wdf_rdy,

    input  logic [C_DATA_WIDTH-1:0]   app_rd_data,
    input  logic                      app_rd_data_valid,

    output logic                      rd_orphan
);

    localparam int MW = C_DATA_WIDTH / 8;
    localparam int TW = $clog2(C_TAG_DEPTH);
    localparam logic [TW:0] FULL_CNT = (TW+1)'(C_TAG_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

    state_t                  state_q, state_d;
    logic                    port_q, port_d;
    logic                    en_q, en_d;
    logic                    wren_q, wren_d;
    logic [2:0]              cmd_q, cmd_d;
    logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [C_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [MW-1:0]           wmask_q, wmask_d;
    logic [1:0]              rdy_q, rdy_d;
    logic [1:0]              rvalid_q, rvalid_d;
    logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                    orphan_q, orphan_d;

    logic                    tag_mem [C_TAG_DEPTH];
    logic [TW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [TW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [TW:0]             cnt_q, cnt_d;

    logic full, empty, push, pop;
    logic elig0, elig1, win1, grant, sel_rnw;
    logic wr_done;

    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);
    assign push  = (state_q == S_RD) && app_rdy;
    assign pop   = app_rd_data_valid && !empty;

    // A port whose ready pulse is showing is still holding the request
    // just served, so it must not be granted again this cycle.
    assign elig0 = p0_cmd_valid && !rdy_q[0] && (!p0_cmd_rnw || !full);
    assign elig1 = p1_cmd_valid && !rdy_q[1] && (!p1_cmd_rnw || !full);

    assign grant = (state_q == S_IDLE) && init_calib_complete
                   && (elig0 || elig1);

`ifdef DDR3_ARB_PRIO_EN
    assign win1 = elig1 && !elig0;
`else
    // prio_q names the port that wins the next tie.
    logic prio_q;

    assign win1 = elig1 && (!elig0 || prio_q);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            prio_q <= 1'b0;
        end else if (grant) begin
            prio_q <= !win1;
        end
    end
`endif

    assign sel_rnw = win1 ? p1_cmd_rnw : p0_cmd_rnw;
    assign wr_done = (!en_q || app_rdy) && (!wren_q || app_wdf_rdy);

    // State and datapath registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= S_IDLE;
            port_q   <= 1'b0;
            en_q     <= 1'b0;
            wren_q   <= 1'b0;
            cmd_q    <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            rdy_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            orphan_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            port_q   <= port_d;
            en_q     <= en_d;
            wren_q   <= wren_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
            rdy_q    <= rdy_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            orphan_q <= orphan_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) begin
            tag_mem[wr_ptr_q] <= port_q;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (grant) state_d = sel_rnw ? S_RD : S_WR;
            S_RD:   if (app_rdy) state_d = S_IDLE;
            S_WR:   if (wr_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and tag FIFO
    always_comb begin
        port_d   = port_q;
        en_d     = en_q;
        wren_d   = wren_q;
        cmd_d    = cmd_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        rdy_d    = '0;
        rvalid_d = '0;
        rdata_d  = rdata_q;
        orphan_d = orphan_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (grant) begin
                    port_d  = win1;
                    en_d    = 1'b1;
                    wren_d  = !sel_rnw;
                    cmd_d   = {2'b00, sel_rnw};
                    addr_d  = win1 ? p1_addr  : p0_addr;
                    wdata_d = win1 ? p1_wdata : p0_wdata;
                    wmask_d = win1 ? p1_wmask : p0_wmask;
                end
            end
            S_RD: begin
                if (app_rdy) begin
                    en_d = 1'b0;
                    rdy_d[port_q] = 1'b1;
                end
            end
            S_WR: begin
                if (app_rdy) en_d = 1'b0;
                if (app_wdf_rdy) wren_d = 1'b0;
                if (wr_done) rdy_d[port_q] = 1'b1;
            end
            default: ;
        endcase

        if (app_rd_data_valid) begin
            if (empty) begin
                orphan_d = 1'b1;
            end else begin
                rvalid_d[tag_mem[rd_ptr_q]] = 1'b1;
                rdata_d = app_rd_data;
            end
        end

        if (push) wr_ptr_d = wr_ptr_q + TW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + TW'(1);
        if (push && !pop) cnt_d = cnt_q + (TW+1)'(1);
        if (pop && !push) cnt_d = cnt_q - (TW+1)'(1);
    end

    assign app_en       = en_q;
    assign app_cmd      = cmd_q;
    assign app_addr     = addr_q;
    assign app_wdf_wren = wren_q;
    assign app_wdf_end  = wren_q;
    assign app_wdf_data = wdata_q;
    assign app_wdf_mask = wmask_q;
    assign p0_cmd_ready = rdy_q[0];
    assign p1_cmd_ready = rdy_q[1];
    assign p0_rvalid    = rvalid_q[0];
    assign p1_rvalid    = rvalid_q[1];
    assign rdata        = rdata_q;
    assign rd_orphan    = orphan_q;

endmodule
